// File: rtl/debug_dump_ctrl.sv
// ---------------------------------------------------------------------------
// debug_dump_ctrl
//
// Post-halt state dump sequencer for the debug unit. After a start request
// it streams the current PC, every register-bank entry (R0..R(BANK_SIZE-1))
// and a window of data-memory words (DM[0]..DM[DM_WORDS-1]) to the UART TX
// path, one word per start/done handshake.
//
// Ports:
//   clk, rst    : system clock, synchronous active-high reset
//   start       : one-cycle request to begin a dump (ignored while busy)
//   current_pc  : PC value from the pipeline
//   RB_Data     : register-bank read data for RB_Addr
//   DM_Data     : data-memory read data for DM_Addr
//   tx_done     : UART finished sending the current word
//   RB_Addr     : register-bank read address (debug side)
//   DM_Addr     : data-memory byte address, word aligned (debug side)
//   tx_start    : one-cycle pulse requesting transmission of tx_Data
//   tx_Data     : word to transmit, zero-extended/truncated to NBITS
//   busy        : high while a dump is in progress (including FINISH)
//   done        : one-cycle pulse after the last word has been sent
// ---------------------------------------------------------------------------
module debug_dump_ctrl #(
    parameter int IM_ADDR_LENGTH = 32,
    parameter int RBITS          = 5,
    parameter int BANK_SIZE      = 32,
    parameter int REG_WIDTH      = 32,
    parameter int DM_ADDR_LENGTH = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int DM_WORDS       = 16,
    parameter int NBITS          = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [IM_ADDR_LENGTH-1:0] current_pc,
    input  logic [REG_WIDTH-1:0]      RB_Data,
    input  logic [DATA_WIDTH-1:0]     DM_Data,
    input  logic                      tx_done,
    output logic [RBITS-1:0]          RB_Addr,
    output logic [DM_ADDR_LENGTH-1:0] DM_Addr,
    output logic                      tx_start,
    output logic [NBITS-1:0]          tx_Data,
    output logic                      busy,
    output logic                      done
);

    localparam int MAX_CNT = (BANK_SIZE > DM_WORDS) ? BANK_SIZE : DM_WORDS;
    localparam int IDX_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    localparam logic [IDX_W-1:0] LAST_REG = IDX_W'((BANK_SIZE > 0) ? BANK_SIZE - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_MEM = IDX_W'((DM_WORDS > 0) ? DM_WORDS - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LATCH,
        S_SEND,
        S_WAIT,
        S_FINISH
    } state_t;

    typedef enum logic [1:0] {
        PH_PC,
        PH_REG,
        PH_MEM
    } phase_t;

    state_t           state, state_n;
    phase_t           phase, phase_n;
    logic [IDX_W-1:0] index, index_n;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            phase <= PH_PC;
            index <= '0;
        end else begin
            state <= state_n;
            phase <= phase_n;
            index <= index_n;
        end
    end

    // Next-state logic; tx_done is only looked at in S_WAIT
    always_comb begin
        state_n = state;
        phase_n = phase;
        index_n = index;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_ADDR;
                    phase_n = PH_PC;
                    index_n = '0;
                end
            end
            S_ADDR:  state_n = S_LATCH;
            S_LATCH: state_n = S_SEND;
            S_SEND:  state_n = S_WAIT;
            S_WAIT: begin
                if (tx_done) begin
                    unique case (phase)
                        PH_PC: begin
                            phase_n = PH_REG;
                            index_n = '0;
                            state_n = S_ADDR;
                        end
                        PH_REG: begin
                            if (index != LAST_REG) begin
                                index_n = index + IDX_W'(1);
                                state_n = S_ADDR;
                            end else if (DM_WORDS > 0) begin
                                phase_n = PH_MEM;
                                index_n = '0;
                                state_n = S_ADDR;
                            end else begin
                                state_n = S_FINISH;
                            end
                        end
                        PH_MEM: begin
                            if (index != LAST_MEM) begin
                                index_n = index + IDX_W'(1);
                                state_n = S_ADDR;
                            end else begin
                                state_n = S_FINISH;
                            end
                        end
                        default: state_n = S_FINISH;
                    endcase
                end
            end
            S_FINISH: state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    // Outputs decoded from the current state
    always_comb begin
        tx_start = (state == S_SEND);
        done     = (state == S_FINISH);
        busy     = (state != S_IDLE);
    end

    // Address and data registers. The debug addresses are loaded on the edge
    // that enters S_ADDR, so they are already stable for the whole S_ADDR
    // cycle; a memory with one cycle of read latency then presents its data
    // during S_LATCH, where it is captured. Addresses hold until the next
    // entry into S_ADDR for their phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            RB_Addr <= '0;
            DM_Addr <= '0;
            tx_Data <= '0;
        end else begin
            if (state_n == S_ADDR && phase_n == PH_REG) begin
                RB_Addr <= RBITS'(index_n);
            end
            if (state_n == S_ADDR && phase_n == PH_MEM) begin
                DM_Addr <= DM_ADDR_LENGTH'({index_n, 2'b00});
            end
            if (state == S_LATCH) begin
                unique case (phase)
                    PH_PC:   tx_Data <= NBITS'(current_pc);
                    PH_REG:  tx_Data <= NBITS'(RB_Data);
                    PH_MEM:  tx_Data <= NBITS'(DM_Data);
                    default: tx_Data <= tx_Data;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_debug_dump_ctrl.sv
// ---------------------------------------------------------------------------
// tb_debug_dump_ctrl
//
// Testbench for debug_dump_ctrl. Two instances: the default configuration
// (32 registers, 16 DM words) and a small one (4 registers, no DM words).
// Both register bank and data memory are modelled with one cycle of read
// latency. Expected word streams are built directly from the dump order
// (PC, registers, memory words) held in the bench's own arrays.
// ---------------------------------------------------------------------------
module tb_debug_dump_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, start_s, tx_done;
    logic [31:0] pc;

    logic [31:0] rb_mem [32];
    logic [31:0] dm_mem [16];
    logic [31:0] rb_s   [4];
    logic [31:0] rb_data, dm_data, rb_data_s;

    logic [4:0]  rb_addr;
    logic [31:0] dm_addr, td;
    logic        ts, busy, dn;

    logic [1:0]  rb_addr_s;
    logic [31:0] dm_addr_s, td_s;
    logic        ts_s, busy_s, dn_s;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] got[$];
    int          rba[$];
    logic [31:0] dma[$];
    int          ndone;

    debug_dump_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .current_pc(pc),
        .RB_Data(rb_data), .DM_Data(dm_data), .tx_done(tx_done),
        .RB_Addr(rb_addr), .DM_Addr(dm_addr), .tx_start(ts),
        .tx_Data(td), .busy(busy), .done(dn)
    );

    debug_dump_ctrl #(.RBITS(2), .BANK_SIZE(4), .DM_WORDS(0)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .current_pc(pc),
        .RB_Data(rb_data_s), .DM_Data(dm_data), .tx_done(tx_done),
        .RB_Addr(rb_addr_s), .DM_Addr(dm_addr_s), .tx_start(ts_s),
        .tx_Data(td_s), .busy(busy_s), .done(dn_s)
    );

    // Synchronous-read memories (one cycle latency)
    always @(posedge clk) begin
        rb_data   <= rb_mem[rb_addr];
        dm_data   <= dm_mem[dm_addr[5:2]];
        rb_data_s <= rb_s[rb_addr_s];
    end

    typedef struct {
        logic        st;
        logic        txd;
        logic        busy;
        logic        ts;
        logic        dn;
        logic [31:0] data;
        logic [1:0]  rb;
    } vec_t;

    vec_t tv [25];

    function automatic vec_t mk(input logic st, input logic txd, input logic b,
                                input logic t, input logic d,
                                input logic [31:0] data, input logic [1:0] rb);
        vec_t v;
        v.st = st; v.txd = txd; v.busy = b; v.ts = t; v.dn = d;
        v.data = data; v.rb = rb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic do_start(input bit sm);
        @(negedge clk);
        if (sm) start_s = 1'b1; else start = 1'b1;
        @(negedge clk);
        start = 1'b0; start_s = 1'b0;
        chk(sm ? "busy_rise_small" : "busy_rise", sm ? busy_s : busy, 1);
    endtask

    task automatic randomize_mem();
        pc = $urandom;
        for (int i = 0; i < 32; i++) rb_mem[i] = $urandom;
        for (int i = 0; i < 16; i++) dm_mem[i] = $urandom;
        for (int i = 0; i < 4; i++)  rb_s[i]   = $urandom;
    endtask

    // Acts as the UART: records each word at tx_start and answers with a
    // one-cycle tx_done a random dmin..dmax cycles later (always in WAIT).
    task automatic run_dump(input bit sm, input int dmin, input int dmax,
                            input int start_at, input int abort_at);
        int quiet, d;
        bit fin;
        got.delete(); rba.delete(); dma.delete();
        ndone = 0; quiet = 0; fin = 1'b0;
        @(negedge clk);
        while (!fin && quiet < 60 && got.size() < 200) begin
            if (sm ? ts_s : ts) begin
                got.push_back(sm ? td_s : td);
                rba.push_back(sm ? int'(rb_addr_s) : int'(rb_addr));
                dma.push_back(sm ? dm_addr_s : dm_addr);
                quiet = 0;
                if (abort_at >= 0 && got.size() == abort_at) return;
                d = dmin + int'($urandom_range(0, dmax - dmin));
                for (int w = 0; w < d; w++) begin
                    @(negedge clk);
                    if (w == 0 && start_at >= 0 && got.size() == start_at) begin
                        if (sm) start_s = 1'b1; else start = 1'b1;
                    end else begin
                        start = 1'b0; start_s = 1'b0;
                    end
                end
                start = 1'b0; start_s = 1'b0;
                tx_done = 1'b1;
                @(negedge clk);
                tx_done = 1'b0;
            end else if (sm ? dn_s : dn) begin
                ndone++;
                fin = 1'b1;
            end else begin
                quiet++;
                @(negedge clk);
            end
        end
        if (fin) begin
            @(negedge clk);
            chk("busy_after_done", sm ? busy_s : busy, 0);
        end
    endtask

    task automatic check_dump(input string tag, input bit sm, input int nb, input int ndm);
        logic [31:0] exp[$];
        exp.push_back(pc);
        for (int i = 0; i < nb; i++)  exp.push_back(sm ? rb_s[i] : rb_mem[i]);
        for (int k = 0; k < ndm; k++) exp.push_back(dm_mem[k]);
        chk({tag, "_count"}, got.size(), exp.size());
        chk({tag, "_done"}, ndone, 1);
        for (int j = 0; j < exp.size() && j < got.size(); j++) begin
            chk($sformatf("%s_w%0d", tag, j), got[j], exp[j]);
            if (j >= 1 && j <= nb) chk($sformatf("%s_rba%0d", tag, j), rba[j], j - 1);
            if (j > nb) chk($sformatf("%s_dma%0d", tag, j), dma[j], (j - 1 - nb) * 4);
            if (sm) chk($sformatf("%s_dm0_%0d", tag, j), dma[j], 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; start_s = 1'b0; tx_done = 1'b0; pc = '0;
        for (int i = 0; i < 32; i++) rb_mem[i] = i * 32'h11;
        for (int k = 0; k < 16; k++) dm_mem[k] = 32'hA000_0000 + k;
        for (int i = 0; i < 4; i++)  rb_s[i]   = 32'h100 + i;

        // Cycle trace of the small instance: {start, tx_done} in, outputs after the edge
        tv[0]  = mk(0, 0, 0, 0, 0, 32'h0,         2'd0);
        tv[1]  = mk(1, 0, 1, 0, 0, 32'h0,         2'd0);
        tv[2]  = mk(0, 0, 1, 0, 0, 32'h0,         2'd0);
        tv[3]  = mk(0, 0, 1, 1, 0, 32'h1234_5678, 2'd0);
        tv[4]  = mk(0, 1, 1, 0, 0, 32'h1234_5678, 2'd0);
        tv[5]  = mk(0, 1, 1, 0, 0, 32'h1234_5678, 2'd0);
        tv[6]  = mk(0, 0, 1, 0, 0, 32'h1234_5678, 2'd0);
        tv[7]  = mk(0, 0, 1, 1, 0, 32'h100,       2'd0);
        tv[8]  = mk(0, 0, 1, 0, 0, 32'h100,       2'd0);
        tv[9]  = mk(0, 1, 1, 0, 0, 32'h100,       2'd1);
        tv[10] = mk(0, 0, 1, 0, 0, 32'h100,       2'd1);
        tv[11] = mk(0, 0, 1, 1, 0, 32'h101,       2'd1);
        tv[12] = mk(0, 1, 1, 0, 0, 32'h101,       2'd1);
        tv[13] = mk(0, 1, 1, 0, 0, 32'h101,       2'd2);
        tv[14] = mk(0, 0, 1, 0, 0, 32'h101,       2'd2);
        tv[15] = mk(0, 0, 1, 1, 0, 32'h102,       2'd2);
        tv[16] = mk(0, 0, 1, 0, 0, 32'h102,       2'd2);
        tv[17] = mk(0, 1, 1, 0, 0, 32'h102,       2'd3);
        tv[18] = mk(0, 0, 1, 0, 0, 32'h102,       2'd3);
        tv[19] = mk(0, 0, 1, 1, 0, 32'h103,       2'd3);
        tv[20] = mk(1, 0, 1, 0, 0, 32'h103,       2'd3);
        tv[21] = mk(0, 1, 1, 0, 1, 32'h103,       2'd3);
        tv[22] = mk(1, 0, 0, 0, 0, 32'h103,       2'd3);
        tv[23] = mk(0, 0, 0, 0, 0, 32'h103,       2'd3);
        tv[24] = mk(1, 0, 1, 0, 0, 32'h103,       2'd3);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_big",   {busy, ts, dn, td, rb_addr, dm_addr}, 0);
        chk("reset_small", {busy_s, ts_s, dn_s, td_s, rb_addr_s, dm_addr_s}, 0);

        pc = 32'h1234_5678;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            start_s = tv[i].st;
            tx_done = tv[i].txd;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i),
                {busy_s, ts_s, dn_s, td_s, rb_addr_s, dm_addr_s},
                {tv[i].busy, tv[i].ts, tv[i].dn, tv[i].data, tv[i].rb, 32'h0});
        end
        start_s = 1'b0; tx_done = 1'b0;

        // Full dump with the fixed pattern
        do_reset();
        pc = 32'h0000_0040;
        do_start(0);
        run_dump(0, 5, 5, -1, -1);
        check_dump("full", 0, 32, 16);

        // tx_done during SEND must not advance; word held while waiting
        pc = 32'h0000_0BAD;
        do_start(0);
        begin
            int k;
            k = 0;
            while (!ts && k < 10) begin @(negedge clk); k++; end
        end
        chk("hs_first_start", ts, 1);
        chk("hs_pc_word", td, pc);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("hs_hold%0d", c), {ts, td}, {1'b0, pc});
            @(negedge clk);
        end
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        begin
            int k;
            k = 0;
            while (!ts && k < 10) begin @(negedge clk); k++; end
        end
        chk("hs_next_word", {ts, td}, {1'b1, rb_mem[0]});
        do_reset();

        // start pulsed while waiting on R7 is ignored
        randomize_mem();
        do_start(0);
        run_dump(0, 1, 6, 9, -1);
        check_dump("midstart", 0, 32, 16);

        // reset in WAIT of R12, stale tx_done, then a fresh dump
        randomize_mem();
        do_start(0);
        run_dump(0, 1, 4, -1, 14);
        chk("abort_r12_word", got[13], rb_mem[12]);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_outputs", {busy, ts, dn, td, rb_addr, dm_addr}, 0);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        chk("abort_stale_done", {busy, ts, dn}, 0);
        @(negedge clk);
        chk("abort_still_idle", {busy, ts, dn}, 0);
        do_start(0);
        run_dump(0, 1, 4, -1, -1);
        check_dump("restart", 0, 32, 16);

        // Random contents and handshake delays
        for (int r = 0; r < 2; r++) begin
            randomize_mem();
            do_start(0);
            run_dump(0, 1, 7, -1, -1);
            check_dump($sformatf("rand%0d", r), 0, 32, 16);
        end

        // Small instance: PC + 4 registers, DM address never moves
        do_reset();
        randomize_mem();
        do_start(1);
        run_dump(1, 1, 3, -1, -1);
        check_dump("small", 1, 4, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
